// File: rtl/hdd_tone_top.sv
// hdd_tone_top: multi-track triangle tone player with serial command load and H-bridge PWM outputs
module hdd_tone_top #(
    parameter int NUM_TRACKS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sck,
    input  logic                  sdi,
    output logic [NUM_TRACKS-1:0] A,
    output logic [NUM_TRACKS-1:0] B,
    output logic [NUM_TRACKS-1:0] C,
    output logic [NUM_TRACKS-1:0] D
);
    localparam int SW = 24 * NUM_TRACKS;

    logic [SW-1:0] shreg_q, shreg_d;
    logic [2:0]    cs_q, cs_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic          commit, tick;

    // shift sdi in MSB first while the load window is open
    always_comb shreg_d = cs ? {shreg_q[SW-2:0], sdi} : shreg_q;

    // shifter lives in the sck domain so narrow sck pulses are never missed
    always_ff @(posedge sck) shreg_q <= shreg_d;

    // cs synchroniser history and free-running PWM counter
    always_comb begin
        cs_d      = {cs_q[1:0], cs};
        pwm_cnt_d = pwm_cnt_q + 8'd1;
    end

    // clk-domain control state
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_q      <= '0;
            pwm_cnt_q <= '0;
        end else begin
            cs_q      <= cs_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // shreg is quiet when synced cs falls, so it can be copied across domains here
    assign commit = cs_q[2] & ~cs_q[1];
    assign tick   = pwm_cnt_q == 8'hff;

    for (genvar k = 0; k < NUM_TRACKS; k++) begin : nc
        logic [15:0] tw_q, tw_d, phase_q, phase_d;
        logic [7:0]  vol_q, vol_d, level_q, level_d, tri_w;
        logic        wave_q, wave_d, waveOut, en;

        // command capture, triangle synthesis from the pre-tick phase, PWM compare
        always_comb begin
            tw_d    = commit ? shreg_q[24*k+8 +: 16] : tw_q;
            vol_d   = commit ? shreg_q[24*k +: 8] : vol_q;
            tri_w   = phase_q[15] ? ~phase_q[14:7] : phase_q[14:7];
            phase_d = tick ? phase_q + tw_q : phase_q;
            level_d = tick ? 8'(({8'd0, tri_w} * {8'd0, vol_q}) >> 8) : level_q;
            wave_d  = pwm_cnt_q < level_q;
        end

        // per-track state
        always_ff @(posedge clk) begin
            if (!reset) begin
                tw_q    <= '0;
                vol_q   <= '0;
                phase_q <= '0;
                level_q <= '0;
                wave_q  <= 1'b0;
            end else begin
                tw_q    <= tw_d;
                vol_q   <= vol_d;
                phase_q <= phase_d;
                level_q <= level_d;
                wave_q  <= wave_d;
            end
        end

        assign waveOut = wave_q;
        assign en      = |vol_q;
        assign A[k]    = waveOut & en;
        assign B[k]    = ~waveOut & en;
        assign C[k]    = ~waveOut & en;
        assign D[k]    = waveOut & en;
    end
endmodule

// File: tb/tb_hdd_tone_top.sv
// tb_hdd_tone_top: directed checks of serial load, tone synthesis and bridge outputs
module tb_hdd_tone_top;
    logic       clk = 0, reset = 0, cs1 = 0, cs4 = 0, sck = 0, sdi = 0;
    logic       a1, b1, c1, d1;
    logic [3:0] a4, b4, c4, d4;
    int         nvec = 0, nerr = 0, t = 0;
    int         s, bad, hi, n;

    always #5 clk = ~clk;

    hdd_tone_top #(.NUM_TRACKS(1)) dut1 (
        .clk(clk), .reset(reset), .cs(cs1), .sck(sck), .sdi(sdi),
        .A(a1), .B(b1), .C(c1), .D(d1)
    );

    hdd_tone_top #(.NUM_TRACKS(4)) dut4 (
        .clk(clk), .reset(reset), .cs(cs4), .sck(sck), .sdi(sdi),
        .A(a4), .B(b4), .C(c4), .D(d4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic shift(input logic [119:0] d, input int k);
        for (int i = k - 1; i >= 0; i--) begin
            sdi = d[i];
            #1 sck = 1;
            #2 sck = 0;
            #2;
        end
    endtask

    task automatic wait_pwm(input logic [7:0] v);
        int m = 0;
        while (dut1.pwm_cnt_q !== v && m < 300) begin
            @(negedge clk);
            m++;
        end
        if (m >= 300) begin
            nerr++;
            $error("FAIL pwm_wait: got timeout want pwm_cnt %0h", v);
        end
    endtask

    task automatic wait_tick();
        wait_pwm(8'hff);
        @(negedge clk);
        t++;
    endtask

    task automatic window(output int sum, output int mis);
        logic w;
        sum = 0;
        mis = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            w = dut1.nc[0].waveOut;
            sum += int'(w);
            mis += int'((a1 !== w) || (d1 !== w) || (b1 !== ~w) || (c1 !== ~w));
        end
    endtask

    initial begin
        clks(3);
        chk("rst_bridge1", {a1, b1, c1, d1}, 0);
        chk("rst_bridge4", {a4, b4, c4, d4}, 0);
        chk("rst_wave1", dut1.nc[0].waveOut, 0);
        chk("rst_wave4", {dut4.nc[3].waveOut, dut4.nc[2].waveOut, dut4.nc[1].waveOut, dut4.nc[0].waveOut}, 0);
        chk("rst_pwm", dut1.pwm_cnt_q, 0);
        reset = 1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bad += int'(|{a1, b1, c1, d1, a4, b4, c4, d4, dut1.nc[0].waveOut});
        end
        chk("idle_activity", bad, 0);
        chk("idle_phase", dut1.nc[0].phase_q, 0);
        cs1 = 1;
        clks(3);
        shift(24'h0abc55, 24);
        cs1 = 0;
        clks(4);
        chk("load1_tw", dut1.nc[0].tw_q, 32'h0abc);
        chk("load1_vol", dut1.nc[0].vol_q, 32'h55);
        cs1 = 1;
        clks(3);
        shift(24'h0114ff, 24);
        reset = 0;
        clks(3);
        chk("midrst_tw", dut1.nc[0].tw_q, 0);
        chk("midrst_vol", dut1.nc[0].vol_q, 0);
        chk("midrst_phase", dut1.nc[0].phase_q, 0);
        chk("midrst_bridge", {a1, b1, c1, d1}, 0);
        reset = 1;
        clks(4);
        cs1 = 0;
        clks(4);
        chk("load2_tw", dut1.nc[0].tw_q, 32'h0114);
        chk("load2_vol", dut1.nc[0].vol_q, 32'hff);
        chk("load2_phase", dut1.nc[0].phase_q, 0);
        cs4 = 1;
        clks(3);
        shift(24'hdeadbe, 24);
        shift(96'h0114ff0217ff0114ff0217ff, 96);
        cs4 = 0;
        clks(4);
        chk("t4_tw0", dut4.nc[0].tw_q, 32'h0217);
        chk("t4_tw1", dut4.nc[1].tw_q, 32'h0114);
        chk("t4_tw2", dut4.nc[2].tw_q, 32'h0217);
        chk("t4_tw3", dut4.nc[3].tw_q, 32'h0114);
        chk("t4_vol", {dut4.nc[3].vol_q, dut4.nc[2].vol_q, dut4.nc[1].vol_q, dut4.nc[0].vol_q}, 32'hffffffff);
        wait_tick();
        chk("tick1_phase", dut1.nc[0].phase_q, 32'h0114);
        chk("tick1_level", dut1.nc[0].level_q, 0);
        chk("t4_phase0", dut4.nc[0].phase_q, 32'h0217);
        chk("t4_phase1", dut4.nc[1].phase_q, 32'h0114);
        chk("t4_phase2", dut4.nc[2].phase_q, 32'h0217);
        chk("t4_phase3", dut4.nc[3].phase_q, 32'h0114);
        wait_tick();
        chk("tick2_phase", dut1.nc[0].phase_q, 32'h0228);
        chk("tick2_level", dut1.nc[0].level_q, 1);
        wait_tick();
        chk("tick3_phase", dut1.nc[0].phase_q, 32'h033c);
        chk("tick3_level", dut1.nc[0].level_q, 3);
        window(s, bad);
        chk("win3_sum", s, 3);
        chk("win3_bridge", bad, 0);
        while (t < 119) wait_tick();
        chk("tick119_level", dut1.nc[0].level_q, 253);
        wait_tick();
        chk("tick120_phase", dut1.nc[0].phase_q, 32'h8160);
        chk("tick120_level", dut1.nc[0].level_q, 254);
        window(s, bad);
        chk("peak_sum", s, 254);
        chk("peak_bridge", bad, 0);
        wait_tick();
        chk("tick121_phase", dut1.nc[0].phase_q, 32'h8274);
        chk("tick121_level", dut1.nc[0].level_q, 252);
        cs1 = 1;
        shift(24'h040080, 24);
        wait_pwm(8'd253);
        cs1 = 0;
        wait_tick();
        chk("coinc_phase", dut1.nc[0].phase_q, 32'h8388);
        chk("coinc_level", dut1.nc[0].level_q, 250);
        chk("coinc_tw", dut1.nc[0].tw_q, 32'h0400);
        chk("coinc_vol", dut1.nc[0].vol_q, 32'h80);
        wait_tick();
        chk("tick123_phase", dut1.nc[0].phase_q, 32'h8788);
        chk("tick123_level", dut1.nc[0].level_q, 124);
        cs1 = 1;
        shift(24'h040000, 24);
        cs1 = 0;
        clks(4);
        chk("mute_vol", dut1.nc[0].vol_q, 0);
        bad = 0;
        hi = 0;
        n = 0;
        while (dut1.pwm_cnt_q !== 8'hff && n < 300) begin
            bad += int'(|{a1, b1, c1, d1});
            hi += int'(dut1.nc[0].waveOut);
            @(negedge clk);
            n++;
        end
        chk("mute_bridge", bad, 0);
        chk("mute_wave_active", hi != 0, 1);
        wait_tick();
        chk("tick124_phase", dut1.nc[0].phase_q, 32'h8b88);
        chk("tick124_level", dut1.nc[0].level_q, 0);
        cs1 = 1;
        shift(24'h040080, 24);
        cs1 = 0;
        clks(4);
        wait_tick();
        chk("tick125_phase", dut1.nc[0].phase_q, 32'h8f88);
        chk("tick125_level", dut1.nc[0].level_q, 116);
        window(s, bad);
        chk("half_sum", s, 116);
        chk("half_bridge", bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
